// File: rtl/duc_quad_pkg.sv
// Shared constants for the quad-lane digital up-converter.
package duc_quad_pkg;
  localparam int  PHASE_W    = 20;
  localparam int  DATA_W     = 16;
  localparam int  LATENCY    = 5;
  localparam int  FRAC_SHIFT = 15;
  localparam int  NUM_LANES  = 4;
  localparam real PI         = 3.14159265358979323846;
endpackage

// File: rtl/duc_nco_lut.sv
// Full-wave cos/sin table with one registered read port; returns {sin, cos}.
module duc_nco_lut
  import duc_quad_pkg::*;
#(
  parameter int LUT_BITS = 10,
  parameter int AMP      = 32767
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LUT_BITS-1:0]   addr_i,
  output logic [2*DATA_W-1:0]   sincos_o
);
  localparam int DEPTH = 1 << LUT_BITS;

  logic [2*DATA_W-1:0] rom [DEPTH];
  logic [2*DATA_W-1:0] sincos_q;

  // Entries are rounded half away from zero at elaboration time.
  for (genvar n = 0; n < DEPTH; n++) begin : g_rom
    localparam real ANG = 2.0 * PI * n / DEPTH;
    localparam real C_R = AMP * $cos(ANG);
    localparam real S_R = AMP * $sin(ANG);
    localparam int  C_I = (C_R >= 0.0) ? $rtoi(C_R + 0.5) : -$rtoi(0.5 - C_R);
    localparam int  S_I = (S_R >= 0.0) ? $rtoi(S_R + 0.5) : -$rtoi(0.5 - S_R);
    assign rom[n] = {DATA_W'(S_I), DATA_W'(C_I)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sincos_q <= '0;
    else     sincos_q <= rom[addr_i];
  end

  assign sincos_o = sincos_q;
endmodule

// File: rtl/duc_quad.sv
// Quad-lane DUC: one complex sample per clock mixed to four real samples per clock.
module duc_quad
  import duc_quad_pkg::*;
#(
  parameter int LUT_BITS = 10,
  parameter int AMP      = 32767
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         data_in,
  input  logic                valid_in,
  input  logic [PHASE_W-1:0]  pinc,
  input  logic [PHASE_W-1:0]  poff,
  input  logic                p_valid,
  input  logic                resync,
  output logic                valid_out,
  output logic [DATA_W-1:0]   data_out_0,
  output logic [DATA_W-1:0]   data_out_1,
  output logic [DATA_W-1:0]   data_out_2,
  output logic [DATA_W-1:0]   data_out_3
);
  logic [PHASE_W-1:0]        pinc_q, poff_q, acc_q, acc_d;
  logic                      configured_q;
  logic [LATENCY-1:0]        vld_q;
  logic [PHASE_W-1:0]        phi_d [NUM_LANES];
  logic [PHASE_W-1:0]        phi_q [NUM_LANES];
  logic [31:0]               iq1_q, iq2_q;
  logic [2*DATA_W-1:0]       sincos [NUM_LANES];
  logic signed [2*DATA_W-1:0] prod_c_q [NUM_LANES];
  logic signed [2*DATA_W-1:0] prod_s_q [NUM_LANES];
  logic signed [2*DATA_W:0]   diff_q [NUM_LANES];
  logic [DATA_W-1:0]         dout_q [NUM_LANES];
  logic [PHASE_W-1:0]        base, pinc2;

  function automatic logic [DATA_W-1:0] round_sat(input logic signed [2*DATA_W:0] d);
    logic signed [2*DATA_W:0] r;
    r = (d + 33'sd16384) >>> FRAC_SHIFT;
    if (r > 33'sd32767)       return 16'h7fff;
    else if (r < -33'sd32768) return 16'h8000;
    else                      return r[DATA_W-1:0];
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (resync)                       acc_d = '0;
    else if (valid_in && configured_q) acc_d = acc_q + {pinc_q[PHASE_W-3:0], 2'b00};
  end

  always_comb begin
    base     = acc_q + poff_q;
    pinc2    = {pinc_q[PHASE_W-2:0], 1'b0};
    phi_d[0] = base;
    phi_d[1] = base + pinc_q;
    phi_d[2] = base + pinc2;
    phi_d[3] = base + pinc_q + pinc2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pinc_q       <= '0;
      poff_q       <= '0;
      acc_q        <= '0;
      configured_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (p_valid) begin
        pinc_q       <= pinc;
        poff_q       <= poff;
        configured_q <= 1'b1;
      end
    end
  end

  // Zeroing I/Q while unconfigured makes the rest of the datapath produce 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      iq1_q <= '0;
      iq2_q <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        phi_q[k]    <= '0;
        prod_c_q[k] <= '0;
        prod_s_q[k] <= '0;
        diff_q[k]   <= '0;
        dout_q[k]   <= '0;
      end
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], valid_in};
      iq1_q <= configured_q ? data_in : '0;
      iq2_q <= iq1_q;
      for (int k = 0; k < NUM_LANES; k++) begin
        phi_q[k]    <= phi_d[k];
        prod_c_q[k] <= 32'($signed(iq2_q[15:0]))  * 32'($signed(sincos[k][15:0]));
        prod_s_q[k] <= 32'($signed(iq2_q[31:16])) * 32'($signed(sincos[k][31:16]));
        diff_q[k]   <= 33'(prod_c_q[k]) - 33'(prod_s_q[k]);
        if (vld_q[LATENCY-2]) dout_q[k] <= round_sat(diff_q[k]);
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic unused_phase_lsb;
    assign unused_phase_lsb = ^phi_q[k][PHASE_W-LUT_BITS-1:0];

    duc_nco_lut #(
      .LUT_BITS (LUT_BITS),
      .AMP      (AMP)
    ) u_lut (
      .clk      (clk),
      .rst      (rst),
      .addr_i   (phi_q[k][PHASE_W-1 -: LUT_BITS]),
      .sincos_o (sincos[k])
    );
  end

  assign valid_out  = vld_q[LATENCY-1];
  assign data_out_0 = dout_q[0];
  assign data_out_1 = dout_q[1];
  assign data_out_2 = dout_q[2];
  assign data_out_3 = dout_q[3];
endmodule

// File: tb/tb_duc_quad.sv
// Directed-vector bench for duc_quad with hand-computed expected samples.
module tb_duc_quad;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in;
  logic        valid_in;
  logic [19:0] pinc, poff;
  logic        p_valid, resync;
  logic        valid_out;
  logic [15:0] data_out_0, data_out_1, data_out_2, data_out_3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  duc_quad dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .pinc       (pinc),
    .poff       (poff),
    .p_valid    (p_valid),
    .resync     (resync),
    .valid_out  (valid_out),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .data_out_3 (data_out_3)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_valid(input string tag, input int exp);
    chk(tag, {31'b0, valid_out}, exp);
  endtask

  task automatic chk_lanes(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_l0"}, $signed(data_out_0), e0);
    chk({tag, "_l1"}, $signed(data_out_1), e1);
    chk({tag, "_l2"}, $signed(data_out_2), e2);
    chk({tag, "_l3"}, $signed(data_out_3), e3);
  endtask

  function automatic logic [31:0] iq(input int i, input int q);
    return {q[15:0], i[15:0]};
  endfunction

  task automatic configure(input logic [19:0] inc, input logic [19:0] off, input logic rs);
    valid_in = 1'b0;
    p_valid  = 1'b1;
    resync   = rs;
    pinc     = inc;
    poff     = off;
    step(1);
    p_valid  = 1'b0;
    resync   = 1'b0;
  endtask

  initial begin
    valid_in = 1'b0;
    data_in  = '0;
    pinc     = '0;
    poff     = '0;
    p_valid  = 1'b0;
    resync   = 1'b0;

    // reset state
    step(2);
    chk_valid("rst_valid", 0);
    chk_lanes("rst", 0, 0, 0, 0);
    rst = 1'b0;
    step(1);

    // unconfigured: valid tracks, data forced to zero
    valid_in = 1'b1;
    data_in  = iq(1000, 0);
    step(4);
    chk_valid("unc_lat4", 0);
    step(1);
    chk_valid("unc_valid", 1);
    chk_lanes("unc", 0, 0, 0, 0);

    // basic tone
    configure(20'h00000, 20'h00000, 1'b0);
    valid_in = 1'b1;
    data_in  = iq(1000, 0);
    step(4);
    chk_valid("tone_lat4", 0);
    step(1);
    chk_valid("tone_valid", 1);
    chk_lanes("tone", 1000, 1000, 1000, 1000);

    // asynchronous reset mid-stream, then stays unconfigured
    rst = 1'b1;
    #1;
    chk_valid("arst_valid", 0);
    chk_lanes("arst", 0, 0, 0, 0);
    step(1);
    rst = 1'b0;
    step(5);
    chk_valid("post_rst_valid", 1);
    chk_lanes("post_rst", 0, 0, 0, 0);

    // 90 degree offset
    configure(20'h00000, 20'h40000, 1'b0);
    valid_in = 1'b1;
    data_in  = iq(0, 1000);
    step(5);
    chk_lanes("off_q", -1000, -1000, -1000, -1000);
    data_in = iq(1000, 0);
    step(5);
    chk_lanes("off_i", 0, 0, 0, 0);

    // quarter-turn lane stepping, resync and gap
    configure(20'h40000, 20'h00000, 1'b0);
    valid_in = 1'b1;
    data_in  = iq(1000, 0);
    step(5);
    chk_lanes("lane", 1000, 0, -1000, 0);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    step(4);
    chk_lanes("lane_rs", 1000, 0, -1000, 0);
    step(1);
    chk_lanes("lane_post_rs", 1000, 0, -1000, 0);
    valid_in = 1'b0;
    step(1);
    valid_in = 1'b1;
    step(4);
    chk_valid("gap_valid", 0);
    chk_lanes("gap_hold", 1000, 0, -1000, 0);
    step(1);
    chk_valid("gap_after", 1);
    chk_lanes("gap_after", 1000, 0, -1000, 0);

    // saturation at 45 degrees
    configure(20'h00000, 20'h20000, 1'b0);
    valid_in = 1'b1;
    data_in  = iq(32767, -32768);
    step(5);
    chk_lanes("sat_pos", 32767, 32767, 32767, 32767);
    data_in = iq(-32768, 32767);
    step(5);
    chk_lanes("sat_neg", -32768, -32768, -32768, -32768);

    // single-cycle pulse latency and resync repeat of the initial phase
    configure(20'h08000, 20'h00000, 1'b1);
    valid_in = 1'b1;
    data_in  = iq(1000, 0);
    step(1);
    valid_in = 1'b0;
    step(3);
    chk_valid("pulse_lat4", 0);
    step(1);
    chk_valid("pulse_valid", 1);
    chk("pulse_l0", $signed(data_out_0), 1000);
    chk("pulse_l2", $signed(data_out_2), 924);
    step(1);
    chk_valid("pulse_end", 0);

    valid_in = 1'b1;
    step(1);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    step(1);
    valid_in = 1'b0;
    step(2);
    chk("rs_a_l0", $signed(data_out_0), 707);
    step(1);
    chk("rs_b_l0", $signed(data_out_0), 0);
    step(1);
    chk("rs_c_l0", $signed(data_out_0), 1000);
    chk("rs_c_l2", $signed(data_out_2), 924);
    chk_valid("rs_c_valid", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
